operand_fetch: RTL and testbench

- Read-side counterpart to the general-purpose register bank.
- Accepts a two-operand fetch request, reads both source registers through the bank's single read port in successive cycles, and presents the operand pair to the ALU over a valid/ready handshake.
- Applies the same write-through bypass as the register write path, so a writeback in flight is never missed.

---
 rtl/operand_fetch.sv | 87 ++++++++
 tb/tb_operand_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source registers through the bank's single read port
// with writeback bypass, then hands the operand pair to the ALU via valid/ready.
module operand_fetch #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [WIDTH-1:0]  rf_rdata,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [WIDTH-1:0]  op_a,
    output logic [WIDTH-1:0]  op_b
);
    typedef enum logic [1:0] {IDLE, READ_A, READ_B, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              valid_q, valid_d;
    logic              hit_ra, hit_rb;

    assign hit_ra    = wb_en && wb_addr == ra_q;
    assign hit_rb    = wb_en && wb_addr == rb_q;
    assign req_ready = state_q == IDLE;
    assign rf_raddr  = state_q == READ_A ? ra_q : state_q == READ_B ? rb_q : '0;
    assign op_valid  = valid_q;
    assign op_a      = a_q;
    assign op_b      = b_q;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (req_valid) begin
                ra_d    = req_ra;
                rb_d    = req_rb;
                state_d = READ_A;
            end
            READ_A: begin
                a_d     = hit_ra ? wb_data : rf_rdata;
                state_d = READ_B;
            end
            // A was captured a cycle ago, so a writeback to ra now must still reach it
            READ_B: begin
                b_d     = hit_rb ? wb_data : rf_rdata;
                a_d     = hit_ra ? wb_data : a_q;
                valid_d = 1'b1;
                state_d = DONE;
            end
            default: if (op_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a behavioural register bank.
module tb_operand_fetch;
    logic        clk = 0, rst_b = 0;
    logic        req_valid = 0, req_ready;
    logic [2:0]  req_ra = 0, req_rb = 0, rf_raddr;
    logic [15:0] rf_rdata;
    logic        wb_en = 0;
    logic [2:0]  wb_addr = 0;
    logic [15:0] wb_data = 0;
    logic        op_valid, op_ready = 0;
    logic [15:0] op_a, op_b;
    logic [15:0] bank [8];
    int checks = 0, errors = 0;

    operand_fetch dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .op_valid(op_valid),
        .op_ready(op_ready), .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;
    assign rf_rdata = bank[rf_raddr];
    always @(posedge clk) if (wb_en) bank[wb_addr] <= wb_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    // issue a request and run to DONE, optionally writing back during READ_A / READ_B
    task automatic go(input logic [2:0] ra, input logic [2:0] rb,
                      input logic ae, input logic [2:0] aa, input logic [15:0] ad,
                      input logic be, input logic [2:0] ba, input logic [15:0] bd);
        req_valid = 1; req_ra = ra; req_rb = rb;
        tick();
        req_valid = 0; wb_en = ae; wb_addr = aa; wb_data = ad;
        tick();
        wb_en = be; wb_addr = ba; wb_data = bd;
        tick();
        wb_en = 0;
    endtask

    task automatic handshake;
        op_ready = 1;
        tick();
        op_ready = 0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        checks++; if (op_a !== 16'h0 || op_b !== 16'h0) begin errors++; $display("FAIL reset_ops got=%h/%h exp=0/0", op_a, op_b); end
        checks++; if (rf_raddr !== 3'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", rf_raddr); end
        #1 rst_b = 1;
        tick();
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h0);
    endtask

    task automatic test_basic;
        wr(2, 16'h1234); wr(5, 16'hBEEF);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got=%b exp=1", req_ready); end
        req_valid = 1; req_ra = 2; req_rb = 5;
        tick();
        req_valid = 0;
        checks++; if (rf_raddr !== 3'd2 || req_ready !== 1'b0) begin errors++; $display("FAIL basic_read_a got raddr=%0d ready=%b exp 2/0", rf_raddr, req_ready); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got=%b exp=0", op_valid); end
        tick();
        checks++; if (rf_raddr !== 3'd5) begin errors++; $display("FAIL basic_read_b got=%0d exp=5", rf_raddr); end
        tick();
        checks++; if (op_valid !== 1'b1 || rf_raddr !== 3'd0) begin errors++; $display("FAIL basic_done got valid=%b raddr=%0d exp 1/0", op_valid, rf_raddr); end
        checks++; if (op_a !== 16'h1234 || op_b !== 16'hBEEF) begin errors++; $display("FAIL basic_ops got=%h/%h exp=1234/beef", op_a, op_b); end
        handshake();
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL basic_return got valid=%b ready=%b exp 0/1", op_valid, req_ready); end
    endtask

    task automatic test_bypass_a;
        wr(3, 16'h0001);
        go(3, 0, 1, 3, 16'h00FF, 0, 0, 0);
        checks++; if (op_a !== 16'h00FF || op_b !== 16'h0) begin errors++; $display("FAIL bypass_a got=%h/%h exp=00ff/0000", op_a, op_b); end
        handshake();
    endtask

    task automatic test_bypass_b_snoop;
        wr(1, 16'h1111); wr(4, 16'h4444);
        go(1, 4, 0, 0, 0, 1, 1, 16'hAAAA);
        checks++; if (op_a !== 16'hAAAA || op_b !== 16'h4444) begin errors++; $display("FAIL snoop_a got=%h/%h exp=aaaa/4444", op_a, op_b); end
        handshake();
        go(1, 4, 0, 0, 0, 1, 4, 16'h5555);
        checks++; if (op_a !== 16'hAAAA || op_b !== 16'h5555) begin errors++; $display("FAIL bypass_b got=%h/%h exp=aaaa/5555", op_a, op_b); end
        handshake();
    endtask

    task automatic test_backpressure;
        go(2, 5, 0, 0, 0, 0, 0, 0);
        req_valid = 1; req_ra = 6; req_rb = 6;
        wb_en = 1; wb_addr = 2; wb_data = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (op_valid !== 1'b1 || req_ready !== 1'b0 || op_a !== 16'h1234 || op_b !== 16'hBEEF) begin
                errors++; $display("FAIL backpressure_%0d got valid=%b ready=%b ops=%h/%h exp 1/0 1234/beef", i, op_valid, req_ready, op_a, op_b);
            end
        end
        wb_en = 0; req_valid = 0;
        handshake();
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release got valid=%b ready=%b exp 0/1", op_valid, req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL backpressure_stray_accept got ready=%b exp=1", req_ready); end
    endtask

    task automatic test_same_reg;
        wr(7, 16'h7777);
        go(7, 7, 0, 0, 0, 0, 0, 0);
        checks++; if (op_a !== 16'h7777 || op_b !== 16'h7777) begin errors++; $display("FAIL same_reg got=%h/%h exp=7777/7777", op_a, op_b); end
        handshake();
        go(7, 7, 0, 0, 0, 1, 7, 16'h0707);
        checks++; if (op_a !== 16'h0707 || op_b !== 16'h0707) begin errors++; $display("FAIL same_reg_wb got=%h/%h exp=0707/0707", op_a, op_b); end
        handshake();
    endtask

    task automatic test_reset_midop;
        req_valid = 1; req_ra = 2; req_rb = 5;
        tick();
        req_valid = 0;
        tick();
        rst_b = 0;
        #1;
        checks++; if (op_valid !== 1'b0 || op_a !== 16'h0 || op_b !== 16'h0 || req_ready !== 1'b1 || rf_raddr !== 3'd0) begin
            errors++; $display("FAIL rst_read_b got valid=%b ops=%h/%h ready=%b raddr=%0d exp 0 0/0 1 0", op_valid, op_a, op_b, req_ready, rf_raddr);
        end
        #2 rst_b = 1;
        tick();
        go(2, 5, 0, 0, 0, 0, 0, 0);
        checks++; if (op_valid !== 1'b1 || op_a !== 16'h9999) begin errors++; $display("FAIL rst_pre_done got valid=%b a=%h exp 1/9999", op_valid, op_a); end
        rst_b = 0;
        #1;
        checks++; if (op_valid !== 1'b0 || op_a !== 16'h0 || op_b !== 16'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_done got valid=%b ops=%h/%h ready=%b exp 0 0/0 1", op_valid, op_a, op_b, req_ready);
        end
        #2 rst_b = 1;
        tick();
        go(4, 7, 0, 0, 0, 0, 0, 0);
        checks++; if (op_valid !== 1'b1 || op_a !== 16'h5555 || op_b !== 16'h0707) begin errors++; $display("FAIL rst_recover got valid=%b ops=%h/%h exp 1 5555/0707", op_valid, op_a, op_b); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass_a();
        test_bypass_b_snoop();
        test_backpressure();
        test_same_reg();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
